image_load_ctrl: RTL and testbench

Sequencer that owns the 784-byte image RAM for one inference frame. It accepts the pixel byte stream from the UART receive path and writes it into the RAM in raster order. After the last pixel it pulses the inference start and then gives the inference engine exclusive read access. The read path zero-pads out-of-range addresses. It sits between the UART RX front end, the image RAM, and the CNN inference engine.

---
 rtl/image_load_ctrl.sv | 134 +++++++++++++
 tb/tb_image_load_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/image_load_ctrl.sv
// Image RAM sequencer: writes one 784-byte frame from the UART stream, pulses
// the inference start, then serves zero-padded reads until the engine is done.
module image_load_ctrl #(
    parameter int IMG_BYTES = 784,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [7:0]        ram_wr_data,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [7:0]        ram_rd_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [7:0]        rd_data,
    output logic              infer_start,
    input  logic              infer_done,
    output logic              image_loaded
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_BYTES - 1);
    localparam logic [ADDR_W:0]   IMG_LIM  = (ADDR_W + 1)'(IMG_BYTES);
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                infer_start_q, infer_start_d;
    logic                loaded_q, loaded_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_in_range_q, rd_in_range_d;
    logic                hs;

    always_comb begin
        hs            = rx_valid && (state_q == S_LOAD);
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        rd_valid_d    = rd_req && (state_q == S_RUN);
        rd_in_range_d = rd_in_range_q;

        if (rd_valid_d) begin
            rd_in_range_d = ({1'b0, rd_addr} < IMG_LIM);
        end

        if (hs) begin
            wr_addr_d = pix_cnt_q;
            wr_data_d = rx_data;
        end

        // clear wins over handshake and infer_done; the byte taken with it is dropped
        if (clear) begin
            state_d   = S_LOAD;
            pix_cnt_d = '0;
        end else begin
            wr_en_d = hs;
            unique case (state_q)
                S_LOAD: begin
                    if (hs) begin
                        if (pix_cnt_q == LAST_PIX) begin
                            state_d   = S_START;
                            pix_cnt_d = '0;
                        end else begin
                            pix_cnt_d = pix_cnt_q + CNT_ONE;
                        end
                    end
                end
                S_START: state_d = S_RUN;
                S_RUN: begin
                    if (infer_done) begin
                        state_d = S_LOAD;
                    end
                end
                default: state_d = S_LOAD;
            endcase
        end

        // registered status follows the state being entered
        infer_start_d = (state_d == S_START);
        loaded_d      = (state_d != S_LOAD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_LOAD;
            pix_cnt_q     <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            infer_start_q <= 1'b0;
            loaded_q      <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_in_range_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            infer_start_q <= infer_start_d;
            loaded_q      <= loaded_d;
            rd_valid_q    <= rd_valid_d;
            rd_in_range_q <= rd_in_range_d;
        end
    end

    assign rx_ready     = (state_q == S_LOAD);
    assign ram_wr_en    = wr_en_q;
    assign ram_wr_addr  = wr_addr_q;
    assign ram_wr_data  = wr_data_q;
    assign ram_rd_addr  = rd_addr;
    assign infer_start  = infer_start_q;
    assign image_loaded = loaded_q;
    assign rd_valid     = rd_valid_q;
    // RAM data lands one cycle after the address; out-of-range reads return zero
    assign rd_data      = (rd_valid_q && rd_in_range_q) ? ram_rd_data : 8'h00;

endmodule

// File: tb/tb_image_load_ctrl.sv
// Randomized bench for image_load_ctrl with a frame-level reference model and
// a synchronous-read RAM model attached to the controller.
module tb_image_load_ctrl;

    localparam int IMG_BYTES = 784;
    localparam int ADDR_W    = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, clear, rx_valid, rd_req, infer_done;
    logic [7:0]        rx_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              rx_ready, ram_wr_en, rd_valid, infer_start, image_loaded;
    logic [ADDR_W-1:0] ram_wr_addr, ram_rd_addr;
    logic [7:0]        ram_wr_data, rd_data;
    logic [7:0]        ram_rd_data;

    image_load_ctrl #(.IMG_BYTES(IMG_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .infer_start(infer_start), .infer_done(infer_done), .image_loaded(image_loaded)
    );

    // image RAM with one-cycle synchronous read
    logic [7:0] ram [0:1023];
    always @(posedge clk) begin
        if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= ram[ram_rd_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model: phase 0 = accepting pixels, 1 = start cycle, 2 = engine owns image
    logic [7:0] gold [0:1023];
    int         m_phase, m_cnt;
    bit         m_on = 1'b0;
    bit         e_wr_en, e_rdv;
    int         e_wr_addr;
    logic [7:0] e_wr_data, e_rdd;
    int         n_wr, n_start;

    task automatic tick();
        bit hs;
        if (m_on) begin
            check("rx_ready", rx_ready, m_phase == 0);
            check("ram_rd_addr", ram_rd_addr, rd_addr);
            check("wr_en", ram_wr_en, e_wr_en);
            if (e_wr_en) begin
                check("wr_addr", ram_wr_addr, e_wr_addr);
                check("wr_data", ram_wr_data, e_wr_data);
            end
            check("infer_start", infer_start, m_phase == 1);
            check("image_loaded", image_loaded, m_phase != 0);
            check("rd_valid", rd_valid, e_rdv);
            check("rd_data", rd_data, e_rdd);
        end
        if (ram_wr_en === 1'b1) n_wr++;
        if (infer_start === 1'b1) n_start++;

        if (!rst_n) begin
            m_phase = 0; m_cnt = 0;
            e_wr_en = 0; e_wr_addr = 0; e_wr_data = 8'h00;
            e_rdv = 0; e_rdd = 8'h00;
        end else begin
            hs      = rx_valid && (m_phase == 0);
            e_rdv   = rd_req && (m_phase == 2);
            e_rdd   = (e_rdv && rd_addr < IMG_BYTES) ? gold[rd_addr] : 8'h00;
            e_wr_en = hs && !clear;
            if (hs) begin
                e_wr_addr = m_cnt;
                e_wr_data = rx_data;
            end
            if (e_wr_en) gold[m_cnt] = rx_data;
            if (clear) begin
                m_phase = 0; m_cnt = 0;
            end else if (m_phase == 0) begin
                if (hs) begin
                    m_cnt++;
                    if (m_cnt == IMG_BYTES) begin
                        m_cnt = 0; m_phase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (infer_done) begin
                m_phase = 0;
            end
        end
        m_on = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int n, input bit gaps, input bit rnd_data);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 20 * n + 100) begin
            rx_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            rx_data  = rnd_data ? 8'($urandom) : 8'(k % 256);
            if (rx_valid && rx_ready) k++;
            tick();
            guard++;
        end
        rx_valid = 1'b0;
        check("load_count", k, n);
    endtask

    task automatic do_read(input int a, input logic [7:0] exp);
        rd_req  = 1'b1;
        rd_addr = ADDR_W'(a);
        tick();
        rd_req = 1'b0;
        check($sformatf("rd_valid_%0d", a), rd_valid, 1);
        check($sformatf("rd_data_%0d", a), rd_data, exp);
    endtask

    task automatic release_with_read();
        rd_req = 1'b1; rd_addr = 10'd1; infer_done = 1'b1;
        tick();
        rd_req = 1'b0; infer_done = 1'b0;
        check("rel_rd_valid", rd_valid, 1);
        check("rel_rd_data", rd_data, 8'h01);
        check("rel_rx_ready", rx_ready, 1);
        check("rel_loaded", image_loaded, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]  = 8'h00;
            gold[i] = 8'h00;
        end
        rst_n = 1'b0; clear = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        rd_req = 1'b0; rd_addr = '0; infer_done = 1'b0;
        n_wr = 0; n_start = 0;
        @(posedge clk); #1;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_rx_ready", rx_ready, 1);
        check("rst_wr_addr", ram_wr_addr, 0);
        check("rst_wr_data", ram_wr_data, 0);
        check("rst_rd_data", rd_data, 0);
        tick();

        // frame 1: continuous stream, value = address mod 256
        n_wr = 0; n_start = 0;
        load_frame(IMG_BYTES, 1'b0, 1'b0);
        check("f1_start", infer_start, 1);
        check("f1_loaded", image_loaded, 1);
        check("f1_last_wr", ram_wr_addr, IMG_BYTES - 1);
        tick();
        check("f1_writes", n_wr, IMG_BYTES);
        check("f1_starts", n_start, 1);
        check("f1_start_drop", infer_start, 0);
        do_read(0, 8'h00);
        do_read(783, 8'h0F);
        do_read(784, 8'h00);
        do_read(1023, 8'h00);
        for (int i = 0; i < 30; i++) begin
            rd_req  = 1'b1;
            rd_addr = ADDR_W'($urandom_range(0, 1023));
            tick();
        end
        rd_req = 1'b0;
        tick();
        release_with_read();
        rd_req = 1'b1; rd_addr = 10'd10;
        tick();
        rd_req = 1'b0;
        check("rd_in_load", rd_valid, 0);

        // frame 2: throttled stream
        infer_done = 1'b1;
        tick();
        infer_done = 1'b0;
        load_frame(IMG_BYTES, 1'b1, 1'b0);
        tick();
        tick();
        do_read(0, 8'h00);
        do_read(5, 8'h05);
        do_read(783, 8'h0F);
        release_with_read();

        // frame 3: clear after 300 bytes, with a byte offered in the clear cycle
        load_frame(300, 1'b1, 1'b1);
        clear = 1'b1; rx_valid = 1'b1; rx_data = 8'hAA;
        tick();
        clear = 1'b0; rx_valid = 1'b0;
        check("clr_no_wr", ram_wr_en, 0);
        check("clr_rx_ready", rx_ready, 1);
        n_start = 0;
        load_frame(IMG_BYTES - 1, 1'b1, 1'b1);
        check("clr_no_early_start", n_start, 0);
        check("clr_still_loading", image_loaded, 0);
        load_frame(1, 1'b0, 1'b1);
        check("clr_start", infer_start, 1);
        tick();
        for (int i = 0; i < 40; i++) begin
            rd_req  = 1'($urandom_range(0, 1));
            rd_addr = ADDR_W'($urandom_range(0, 1023));
            tick();
        end
        rd_req = 1'b0;

        // reset for one cycle while the engine owns the image
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rr_rx_ready", rx_ready, 1);
        check("rr_wr_en", ram_wr_en, 0);
        check("rr_wr_addr", ram_wr_addr, 0);
        check("rr_wr_data", ram_wr_data, 0);
        check("rr_rd_valid", rd_valid, 0);
        check("rr_rd_data", rd_data, 0);
        check("rr_start", infer_start, 0);
        check("rr_loaded", image_loaded, 0);
        infer_done = 1'b1;
        tick();
        infer_done = 1'b0;
        check("rr_done_ignored", rx_ready, 1);
        check("rr_done_loaded", image_loaded, 0);
        for (int i = 0; i < 20; i++) begin
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
            tick();
        end
        rx_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
